// File: rtl/fft64_pkg.sv
// rtl/fft64_pkg.sv - shared constants and types for the fft64 frame feeder
package fft64_pkg;

  localparam int DATA_W    = 10;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;

  // Saturating negate: the most negative code has no positive twin,
  // so it maps to the largest positive code instead of wrapping.
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] NEG_SAT = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SEND = 2'd1,
    RD_GAP  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fft64_frame_bank.sv
// rtl/fft64_frame_bank.sv - one frame of sample storage, sync write and sync read
module fft64_frame_bank #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain RAM behaviour: contents are not reset, read data is registered.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft64_feeder.sv
// rtl/fft64_feeder.sv - ping-pong buffer that turns a sample stream into gapped fft64 frames
module fft64_feeder #(
  parameter int DATA_W    = fft64_pkg::DATA_W,
  parameter int FRAME_LEN = fft64_pkg::FRAME_LEN,
  parameter int MIN_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              conj_en,
  input  logic              flush,
  output logic [DATA_W-1:0] m_re,
  output logic [DATA_W-1:0] m_im,
  output logic              m_valid,
  output logic              frame_start,
  output logic              overflow
);

  import fft64_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam int                GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);
  localparam logic [DATA_W-1:0] IM_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] IM_MAX    = {1'b0, {(DATA_W-1){1'b1}}};

  // write side
  logic              run_q;
  logic [1:0]        full_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              accept;
  logic              store;
  logic              wr_last;
  logic [DATA_W-1:0] im_store;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;

  // read side
  rd_state_t         state_q, state_d;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [GAP_W-1:0]  gap_q;
  logic              rd_go;
  logic              release_bank;

  // output stage
  logic              m_valid_q;
  logic              frame_start_q;
  logic              out_bank_q;
  logic              overflow_q;
  logic [2*DATA_W-1:0] rd_data [2];
  logic [2*DATA_W-1:0] out_word;

  // run_q keeps s_ready low during reset and for the edge that leaves it.
  assign s_ready = run_q & ~full_q[wr_bank_q];
  assign accept  = s_valid & s_ready;
  assign store   = accept & ~flush;
  assign wr_last = store & (wr_ptr_q == LAST_ADDR);

  assign im_store = !conj_en       ? s_im   :
                    (s_im == IM_MIN) ? IM_MAX : -s_im;

  // A completing write and a releasing read never touch the same bank.
  assign set_mask = {wr_last & wr_bank_q, wr_last & ~wr_bank_q};
  assign clr_mask = {release_bank & rd_bank_q, release_bank & ~rd_bank_q};

  // Write pointer, bank select, full flags and the sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      full_q     <= (full_q & ~clr_mask) | set_mask;
      overflow_q <= overflow_q | (s_valid & ~s_ready);
      if (flush) begin
        wr_ptr_q <= '0;
      end else if (store) begin
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
    end
  end

  // Read FSM next state: wait for a full bank, stream it, then hold off.
  always_comb begin
    state_d      = state_q;
    rd_go        = 1'b0;
    release_bank = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        rd_go = 1'b1;
        if (rd_ptr_q == LAST_ADDR) begin
          release_bank = 1'b1;
          if (MIN_GAP > 0) begin
            state_d = RD_GAP;
          end else if (full_q[~rd_bank_q]) begin
            state_d = RD_SEND;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
      RD_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = full_q[rd_bank_q] ? RD_SEND : RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Read FSM state, read address, bank toggle and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      gap_q     <= '0;
    end else begin
      state_q <= state_d;
      if (release_bank) begin
        rd_ptr_q  <= '0;
        rd_bank_q <= ~rd_bank_q;
      end else if (rd_go) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (state_q == RD_GAP) begin
        gap_q <= gap_q + 1'b1;
      end else begin
        gap_q <= '0;
      end
    end
  end

  // Output flags line up with the registered RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      out_bank_q    <= 1'b0;
    end else begin
      m_valid_q     <= rd_go;
      frame_start_q <= rd_go & (rd_ptr_q == '0);
      out_bank_q    <= rd_bank_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft64_frame_bank #(
      .WIDTH (2*DATA_W),
      .DEPTH (FRAME_LEN),
      .AW    (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (store & (wr_bank_q == 1'(b))),
      .wr_addr (wr_ptr_q),
      .wr_data ({s_re, im_store}),
      .rd_en   (rd_go & (rd_bank_q == 1'(b))),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data[b])
    );
  end

  assign out_word    = rd_data[out_bank_q];
  assign m_valid     = m_valid_q;
  assign frame_start = frame_start_q;
  assign m_re        = m_valid_q ? out_word[2*DATA_W-1:DATA_W] : '0;
  assign m_im        = m_valid_q ? out_word[DATA_W-1:0]        : '0;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fft64_feeder.sv
// tb/tb_fft64_feeder.sv - scoreboard bench for the fft64 frame feeder
module tb_fft64_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] s_re, s_im;
  logic       s_valid, s_ready, conj_en, flush;
  logic [9:0] m_re, m_im;
  logic       m_valid, frame_start, overflow;

  typedef struct {
    logic [9:0] re;
    logic [9:0] im;
    logic       start;
  } samp_t;

  samp_t exp_q[$];
  samp_t partial[$];
  samp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_edge = 0;
  int rise_edge = 0;
  int frames_out = 0;
  int out_idx = 0;
  int idle_run = 0;
  bit seen_frame = 0;
  bit tight_gap = 0;

  fft64_feeder #(.DATA_W(10), .FRAME_LEN(64), .MIN_GAP(2)) dut (
    .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_valid(s_valid),
    .s_ready(s_ready), .conj_en(conj_en), .flush(flush), .m_re(m_re),
    .m_im(m_im), .m_valid(m_valid), .frame_start(frame_start), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [9:0] sat_neg(input logic [9:0] v);
    int x;
    x = -int'($signed(v));
    if (x > 511) x = 511;
    return x[9:0];
  endfunction

  // Reference: accepted samples gather into a frame; a complete frame of 64
  // becomes 64 expected outputs in acceptance order. Flush drops the partial.
  task automatic model_accept(input logic [9:0] re, input logic [9:0] im,
                              input logic cj, input logic fl);
    samp_t e;
    if (fl) begin
      partial.delete();
      return;
    end
    e.re = re;
    e.im = cj ? sat_neg(im) : im;
    e.start = (partial.size() == 0);
    partial.push_back(e);
    if (partial.size() == 64) begin
      foreach (partial[i]) exp_q.push_back(partial[i]);
      partial.delete();
    end
  endtask

  task automatic push(input logic [9:0] re, input logic [9:0] im, input logic cj,
                      input logic fl, output bit stalled);
    int guard = 0;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        s_valid = 1; s_re = re; s_im = im; conj_en = cj; flush = fl;
        acc_edge = cyc + 1;
        @(posedge clk);
        model_accept(re, im, cj, fl);
        #1 s_valid = 0; flush = 0;
        return;
      end
      s_valid = 0;
      stalled = 1;
      guard++;
      if (guard > 3000) begin
        chk("push_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    s_valid = 0; flush = 1;
    @(posedge clk);
    partial.delete();
    #1 flush = 0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", g < 2000, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    int g = 0;
    while (frames_out < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("frame_started_in_time", g < 2000, 1);
  endtask

  // Monitor: pops the scoreboard on every valid output beat.
  always @(negedge clk) begin
    if (!tight_gap) seen_frame = 0;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_re", m_re, mon_e.re);
        chk("m_im", m_im, mon_e.im);
        chk("frame_start", frame_start, mon_e.start);
      end
      if (frame_start) begin
        rise_edge = cyc;
        frames_out++;
        if (tight_gap && seen_frame) chk("frame_gap", idle_run, 2);
        seen_frame = 1;
        out_idx = 0;
      end
      out_idx++;
      idle_run = 0;
    end else begin
      idle_run++;
      chk("idle_outputs_zero", {m_re, m_im, frame_start}, 0);
    end
  end

  initial begin
    bit st;
    int f0;
    int first_stall;
    logic [9:0] conj_ims [4];
    conj_ims[0] = 10'h200; conj_ims[1] = 10'h3FF; conj_ims[2] = 10'h000; conj_ims[3] = 10'h1FF;

    rst = 1; s_valid = 0; s_re = 0; s_im = 0; conj_en = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_m_re", m_re, 0);
    rst = 0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);

    // ramp frame and first-output latency
    f0 = frames_out;
    for (int k = 0; k < 64; k++) push(10'(k), 10'(-k), 0, 0, st);
    wait_frames(f0 + 1);
    chk("ramp_latency", rise_edge - acc_edge, 2);
    wait_drain();

    // back-to-back stream against both banks
    tight_gap = 1;
    first_stall = -1;
    f0 = frames_out;
    for (int k = 0; k < 192; k++) begin
      push(10'($urandom), 10'($urandom), 0, 0, st);
      if (st && first_stall < 0) first_stall = k;
    end
    chk("ready_drop_after", first_stall, 128);
    wait_drain();
    tight_gap = 0;
    chk("bp_frames", frames_out - f0, 3);
    chk("bp_overflow", overflow, 0);

    // conjugate with saturation corners
    for (int k = 0; k < 64; k++)
      push(10'($urandom), (k < 4) ? conj_ims[k] : 10'($urandom), 1, 0, st);
    wait_drain();

    // flush a partial frame
    f0 = frames_out;
    for (int k = 0; k < 10; k++) push(10'($urandom), 10'($urandom), 0, 0, st);
    flush_pulse();
    for (int k = 0; k < 64; k++) push(10'(100 + k), 10'($urandom), 0, 0, st);
    wait_drain();
    chk("flush_frames", frames_out - f0, 1);

    // random traffic with a flush concurrent with an accept
    for (int k = 0; k < 20; k++) push(10'($urandom), 10'($urandom), 1'($urandom), 0, st);
    push(10'($urandom), 10'($urandom), 0, 1, st);
    for (int k = 0; k < 192; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(10'($urandom), 10'($urandom), 1'($urandom), 0, st);
    end
    wait_drain();

    // reset in the middle of a frame
    f0 = frames_out;
    for (int k = 0; k < 64; k++) push(10'($urandom), 10'($urandom), 0, 0, st);
    wait_frames(f0 + 1);
    for (int g = 0; g < 200 && out_idx < 30; g++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    exp_q.delete();
    partial.delete();
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_re_im", {m_re, m_im}, 0);
    chk("midrst_frame_start", frame_start, 0);
    chk("midrst_s_ready", s_ready, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("s_ready_after_midrst", s_ready, 1);
    for (int k = 0; k < 64; k++) push(10'($urandom), 10'($urandom), 0, 0, st);
    wait_drain();

    // overflow is sticky until reset
    for (int k = 0; k < 128; k++) push(10'($urandom), 10'($urandom), 0, 0, st);
    @(negedge clk);
    chk("both_full_not_ready", s_ready, 0);
    s_valid = 1;
    @(posedge clk);
    #1 s_valid = 0;
    @(negedge clk);
    chk("overflow_set", overflow, 1);
    wait_drain();
    chk("overflow_sticky", overflow, 1);
    rst = 1;
    @(negedge clk);
    chk("overflow_cleared", overflow, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
